mux_reg_arbiter: RTL and testbench
==================================

// Module: mux_reg_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for the shared 4:1 mux + output-register datapath.
//   Four requesters each offer WIDTH-bit data with valid/ready. The block grants one
//   requester at a time, drives the 4:1 select, and loads the winner's data into a
//   single-entry output register. The output register has valid/ready backpressure.
//   A granted requester keeps the path for up to MAX_BURST beats, then the grant rotates.
// PARAMETERS
//   WIDTH      8   data width of each requester and of the output
//   MAX_BURST  4   max beats per grant; legal range 1..15
// PORTS
//   clk        in   1        single clock; all state updates on rising edge
//   rst        in   1        asynchronous, active-low reset (0 = reset)
//   in_valid   in   4        per-requester valid; bit i belongs to requester i
//   in_data0   in   WIDTH    requester 0 data (in_data1..in_data3 likewise)
//   in_ready   out  4        per-requester ready; at most one bit is set
//   out_valid  out  1        output register holds a beat
//   out_data   out  WIDTH    output register data
//   out_src    out  2        index of the requester that produced out_data
//   out_ready  in   1        downstream accepts the beat
//   gnt        out  4        one-hot current grant; all zero in IDLE
//   busy       out  1        1 while state == GRANT
// BEHAVIOUR
//   Reset (rst=0, asynchronous, at any time including mid-burst):
//     - state=IDLE, ptr=0, gnt_idx=0, burst_cnt=0.
//     - out_valid=0, out_data=0, out_src=0, gnt=0, busy=0, in_ready=0.
//   Handshake: a beat transfers when in_valid[i] & in_ready[i].
//     - A requester must hold valid and data stable until its beat transfers.
//     - Downstream accepts when out_valid & out_ready.
//   in_ready[i] = (state==GRANT) & (gnt_idx==i) & (!out_valid | out_ready). Combinational.
//   FSM IDLE:
//     - If any in_valid is set, pick the first set bit scanning ptr, ptr+1, .. mod 4.
//     - Next cycle: state=GRANT, gnt_idx=winner, burst_cnt=0.
//     - Otherwise stay in IDLE.
//     - Arbitration costs one bubble cycle, and in_ready=0 in IDLE.
//   FSM GRANT:
//     - The mux select is gnt_idx.
//     - On a transfer: out_data<=in_data[gnt_idx], out_src<=gnt_idx, out_valid<=1,
//       burst_cnt<=burst_cnt+1.
//     - Release to IDLE with ptr<=(gnt_idx+1) mod 4 and burst_cnt<=0 when either:
//         (a) a transfer happens with burst_cnt==MAX_BURST-1, or
//         (b) in_valid[gnt_idx]==0. The requester is finished, no transfer occurs.
//     - When backpressure stalls a transfer, stay in GRANT with no counter change.
//   Output register:
//     - Load and drain in the same cycle: out_valid stays 1 and the new data replaces the old.
//     - Drain with no load: out_valid<=0, out_data and out_src hold their values.
//     - When out_valid=1 and out_ready=0: out_data and out_src stay stable, no beat is lost.
//   Throughput and latency:
//     - Within a grant, 1 beat per cycle.
//     - in_data reaches out_data 1 cycle after its transfer.
//     - First beat after in_valid rises in IDLE: transfer at cycle +1, out_valid at cycle +2.
//   Fairness: a continuously requesting agent waits at most 3*(MAX_BURST+1) cycles
//   plus downstream stall cycles.
//   ptr wraps 3->0. burst_cnt width is $clog2(MAX_BURST+1) and it never exceeds MAX_BURST-1.
//   Changes to in_valid bits of non-granted requesters do not affect the current grant.
// TESTING
//   1 Reset: assert rst=0 during the 3rd beat of a burst -> out_valid=0, in_ready=0,
//     gnt=0 immediately (asynchronous); after release the first grant goes to the lowest
//     valid index starting from 0.
//   2 Single requester: in_valid=4'b0100, in_data2=8'hA5, out_ready=1
//     -> gnt=4'b0100 at cycle 1, in_ready[2]=1 at cycle 1,
//        out_data=8'hA5 and out_src=2 with out_valid=1 at cycle 2.
//   3 Rotation: in_valid=4'b1111 held with counting data, out_ready=1, MAX_BURST=4
//     -> grants 0,1,2,3,0 in that order, exactly 4 beats each, 1 idle cycle between
//        grants, out_src sequence matches.
//   4 Backpressure: out_ready=0 for 5 cycles while out_valid=1
//     -> in_ready=4'b0000, out_data stable; after out_ready=1 the beats resume in order
//        with no loss or duplication.
//   5 Early release: requester 1 sends 2 beats then drops in_valid[1]
//     -> next cycle state=IDLE, ptr=2, requester 2 is granted next.
//   6 Simultaneous load and drain: out_valid=1, out_ready=1, granted in_valid=1
//     -> out_valid stays 1 and out_data takes the new value with no bubble.

Source files
------------

// File: rtl/mux_reg_arbiter.sv
// Round-robin arbiter sequencing four requesters through a shared 4:1 mux
// into a single-entry output register with valid/ready backpressure.
module mux_reg_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_nxt;
    logic [1:0]     ptr, ptr_nxt;
    logic [1:0]     gnt_idx, gnt_nxt;
    logic [CW-1:0]  burst_cnt, cnt_nxt;
    logic [WIDTH-1:0] mux_data;
    logic [1:0]     pick, cand;
    logic           pick_found;
    logic           sel_valid, path_free, xfer, drain;

    always_comb begin
        mux_data = in_data0;
        unique case (gnt_idx)
            2'd0: mux_data = in_data0;
            2'd1: mux_data = in_data1;
            2'd2: mux_data = in_data2;
            2'd3: mux_data = in_data3;
        endcase
    end

    // Rotating priority scan starting at ptr
    always_comb begin
        pick       = ptr;
        pick_found = 1'b0;
        cand       = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!pick_found && in_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    assign busy      = (state == GRANT);
    assign sel_valid = in_valid[gnt_idx];
    assign path_free = !out_valid || out_ready;
    assign xfer      = busy && sel_valid && path_free;
    assign drain     = out_valid && out_ready;

    always_comb begin
        in_ready = 4'b0000;
        gnt      = 4'b0000;
        if (busy) begin
            gnt = 4'b0001 << gnt_idx;
            if (path_free) begin
                in_ready = 4'b0001 << gnt_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt_idx;
        cnt_nxt   = burst_cnt;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = pick;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!sel_valid || (xfer && burst_cnt == LAST)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_idx + 2'd1;
                    cnt_nxt   = '0;
                end else if (xfer) begin
                    cnt_nxt = burst_cnt + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gnt_idx   <= 2'd0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt_idx   <= gnt_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    // A load takes priority over a drain so a back-to-back beat has no bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_src   <= gnt_idx;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_reg_arbiter.sv
// Scoreboard bench for mux_reg_arbiter: directed arbitration checks
// plus in-order data integrity of every transferred beat.
module tb_mux_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [7:0] data [4];
    logic [3:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_src;
    logic       out_ready;
    logic [3:0] gnt;
    logic       busy;

    int         rem [4];
    logic [3:0] xmask;
    logic [9:0] sb [$];
    int         n_tests = 0;
    int         n_fail  = 0;

    mux_reg_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data0 (data[0]),
        .in_data1 (data[1]),
        .in_data2 (data[2]),
        .in_data3 (data[3]),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready),
        .gnt      (gnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) in_valid[i] = (rem[i] != 0);
    endtask

    // Pop the visible output beat first, then record this cycle's transfers
    task automatic sample();
        logic [9:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                chk("sb_beat", {out_src, out_data}, e);
            end
        end
        xmask = in_valid & in_ready;
        for (int i = 0; i < 4; i++)
            if (xmask[i]) sb.push_back({2'(i), data[i]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (xmask[i]) begin
                rem[i]  = rem[i] - 1;
                data[i] = data[i] + 8'd1;
            end
        end
        xmask = 4'b0;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            sample();
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] e;
        logic [7:0] d0;
        rst       = 1'b0;
        out_ready = 1'b1;
        xmask     = 4'b0;
        for (int i = 0; i < 4; i++) begin
            rem[i]  = 0;
            data[i] = 8'(i << 6);
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {out_valid, out_src, out_data}, 0);
        chk("rst_ctl", {gnt, busy, in_ready}, 0);
        rst = 1'b1;

        // Rotation: bubble then 4 beats per grant, 0,1,2,3,0
        for (int i = 0; i < 4; i++) rem[i] = 100;
        drive();
        for (int c = 0; c < 25; c++) begin
            sample();
            e = (c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
            chk("rot_gnt", {gnt, in_ready}, {e, e});
            tick();
        end

        // Asynchronous reset during 3rd beat of requester 1's grant
        run(3);
        sample();
        chk("pre_rst_gnt", gnt, 4'b0010);
        #2 rst = 1'b0;
        #1;
        chk("rst_async", {out_valid, gnt, in_ready, busy}, 0);
        sb.delete();
        xmask  = 4'b0;
        rem[0] = 0;
        rem[1] = 1;
        rem[2] = 0;
        rem[3] = 1;
        tick();
        rst = 1'b1;
        sample();
        chk("rst_idle", gnt, 4'b0000);
        tick();
        sample();
        chk("rst_first", gnt, 4'b0010);
        tick();
        run(8);

        // Single requester latency
        data[2] = 8'hA5;
        rem[2]  = 1;
        drive();
        sample();
        chk("t2_bubble", {gnt, in_ready}, 0);
        tick();
        sample();
        chk("t2_gnt", {gnt, in_ready}, {4'b0100, 4'b0100});
        tick();
        sample();
        chk("t2_out", {out_valid, out_src, out_data}, {1'b1, 2'd2, 8'hA5});
        tick();
        run(3);

        // Backpressure for 5 cycles while holding a beat
        rem[0] = 6;
        drive();
        run(2);
        out_ready = 1'b0;
        repeat (5) begin
            sample();
            chk("bp_ready", in_ready, 4'b0000);
            chk("bp_hold", {out_valid, out_src, out_data}, {1'b1, sb[0]});
            chk("bp_noload", 32'(sb.size()), 1);
            tick();
        end
        out_ready = 1'b1;
        run(16);

        // Early release of requester 1 after 2 beats
        rem[1] = 2;
        drive();
        sample();
        tick();
        rem[0] = 2;
        rem[2] = 2;
        rem[3] = 2;
        drive();
        sample();
        chk("t5_gnt1", gnt, 4'b0010);
        tick();
        sample();
        tick();
        sample();
        chk("t5_drop", {in_valid[1], busy}, 2'b01);
        tick();
        sample();
        chk("t5_idle", {busy, gnt}, 0);
        tick();
        sample();
        chk("t5_next", gnt, 4'b0100);
        tick();
        run(30);

        // Simultaneous load and drain, no bubble
        d0     = data[3];
        rem[3] = 3;
        drive();
        run(2);
        sample();
        chk("t6_first", {out_valid, out_data}, {1'b1, d0});
        chk("t6_ready", in_ready, 4'b1000);
        tick();
        sample();
        chk("t6_next", {out_valid, out_data}, {1'b1, d0 + 8'd1});
        tick();
        run(6);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
